// File: rtl/fpu_issue_arbiter.sv
// fpu_issue_arbiter: round-robin issue of NREQ requesters into one shared pipelined fadd/fsub unit
// Ports: clk, rstn (async active-low); hold blocks new grants;
//   req_valid/req_ready/req_x1/req_x2/req_sub/req_rd: per-requester op handshake, slice i for requester i;
//   fpu_x1/fpu_x2/fpu_flag/fpu_add: registered op into the unit; fpu_y/fpu_flagout/fpu_addout: its result;
//   res_valid/res_y/res_rd: one-cycle result pulse to the owning requester;
//   busy: anything in flight; err: sticky mismatch between tracked ops and the unit's flag/tag.
module fpu_issue_arbiter #(
    parameter int NREQ   = 2,
    parameter int NSTAGE = 3,
    parameter int MAXOUT = 4,
    parameter int IDW    = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                hold,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [32*NREQ-1:0]  req_x1,
    input  logic [32*NREQ-1:0]  req_x2,
    input  logic [NREQ-1:0]     req_sub,
    input  logic [5*NREQ-1:0]   req_rd,
    output logic [31:0]         fpu_x1,
    output logic [31:0]         fpu_x2,
    output logic                fpu_flag,
    output logic [4:0]          fpu_add,
    input  logic [31:0]         fpu_y,
    input  logic                fpu_flagout,
    input  logic [4:0]          fpu_addout,
    output logic [NREQ-1:0]     res_valid,
    output logic [31:0]         res_y,
    output logic [4:0]          res_rd,
    output logic                busy,
    output logic                err
);
    localparam int CW = $clog2(MAXOUT + 1);
    logic [IDW-1:0] ptr, gid, idx;
    logic [CW-1:0] cnt [NREQ];
    logic [NREQ-1:0] elig, acc, ret;
    logic found, any_v, any_cnt;
    logic pv [NSTAGE+1];
    logic [IDW-1:0] pid [NSTAGE+1];
    logic [4:0] prd [NSTAGE+1];
    logic [31:0] x1, x2;
    logic [4:0] rd;
    logic sub;
    assign x1 = req_x1[32*gid +: 32];
    assign x2 = req_x2[32*gid +: 32];
    assign rd = req_rd[5*gid +: 5];
    assign sub = req_sub[gid];
    assign req_ready = acc;
    assign busy = fpu_flag | any_v | any_cnt;
    always_comb begin
        elig = '0;
        ret = '0;
        gid = ptr;
        idx = '0;
        found = 1'b0;
        any_v = 1'b0;
        any_cnt = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_valid[i] & ~hold & (cnt[i] < CW'(MAXOUT));
            ret[i] = pv[NSTAGE] && pid[NSTAGE] == IDW'(i);
            any_cnt = any_cnt | (cnt[i] != '0);
        end
        // NREQ is a power of two, so wrapping the pointer sum gives the modulo search order
        for (int k = 1; k <= NREQ; k++) begin
            idx = ptr + IDW'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                gid = idx;
            end
        end
        for (int s = 0; s <= NSTAGE; s++) any_v = any_v | pv[s];
        // gating with rstn keeps req_ready low while reset is held
        acc = NREQ'(found & rstn) << gid;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= IDW'(NREQ - 1);
            fpu_x1 <= '0;
            fpu_x2 <= '0;
            fpu_flag <= 1'b0;
            fpu_add <= '0;
            res_valid <= '0;
            res_y <= '0;
            res_rd <= '0;
            err <= 1'b0;
            for (int s = 0; s <= NSTAGE; s++) begin
                pv[s] <= 1'b0;
                pid[s] <= '0;
                prd[s] <= '0;
            end
            for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
        end else begin
            if (|acc) ptr <= gid;
            fpu_flag <= |acc;
            fpu_x1 <= |acc ? x1 : '0;
            fpu_x2 <= |acc ? {x2[31] ^ sub, x2[30:0]} : '0;
            fpu_add <= |acc ? rd : '0;
            pv[0] <= |acc;
            pid[0] <= gid;
            prd[0] <= |acc ? rd : '0;
            for (int s = 1; s <= NSTAGE; s++) begin
                pv[s] <= pv[s-1];
                pid[s] <= pid[s-1];
                prd[s] <= prd[s-1];
            end
            res_valid <= ret;
            if (pv[NSTAGE]) begin
                res_y <= fpu_y;
                res_rd <= fpu_addout;
            end
            for (int i = 0; i < NREQ; i++) cnt[i] <= cnt[i] + CW'(acc[i]) - CW'(ret[i]);
            if (pv[NSTAGE] != fpu_flagout || (pv[NSTAGE] && prd[NSTAGE] != fpu_addout)) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// tb_fpu_issue_arbiter: scoreboard bench for fpu_issue_arbiter with a behavioural pipelined adder
module tb_fpu_issue_arbiter;
    localparam int NREQ = 2;
    localparam int NSTAGE = 3;
    localparam int MAXOUT = 4;
    logic clk, rstn, hold;
    logic [NREQ-1:0] req_valid, req_ready, req_sub, res_valid;
    logic [32*NREQ-1:0] req_x1, req_x2;
    logic [5*NREQ-1:0] req_rd;
    logic [31:0] fpu_x1, fpu_x2, fpu_y, res_y;
    logic [4:0] fpu_add, fpu_addout, res_rd;
    logic fpu_flag, fpu_flagout, busy, err;
    logic [4:0] tag_xor;
    int passed = 0, total = 0, pops = 0, max_out = 0;
    int outst [NREQ];
    typedef struct {int id; logic [4:0] rd; logic [31:0] y;} exp_t;
    exp_t sb [$];
    exp_t e;
    int gq [$];
    logic [31:0] mb;
    fpu_issue_arbiter #(.NREQ(NREQ), .NSTAGE(NSTAGE), .MAXOUT(MAXOUT)) dut (
        .clk(clk), .rstn(rstn), .hold(hold), .req_valid(req_valid), .req_ready(req_ready),
        .req_x1(req_x1), .req_x2(req_x2), .req_sub(req_sub), .req_rd(req_rd),
        .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_flag(fpu_flag), .fpu_add(fpu_add),
        .fpu_y(fpu_y), .fpu_flagout(fpu_flagout), .fpu_addout(fpu_addout),
        .res_valid(res_valid), .res_y(res_y), .res_rd(res_rd), .busy(busy), .err(err)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    // stand-in FPU: integer add, NSTAGE edges from fpu_* to outputs
    logic [31:0] sy [NSTAGE];
    logic sf [NSTAGE];
    logic [4:0] sa [NSTAGE];
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < NSTAGE; s++) begin
                sy[s] <= '0;
                sf[s] <= 1'b0;
                sa[s] <= '0;
            end
        end else begin
            sy[0] <= fpu_x1 + fpu_x2;
            sf[0] <= fpu_flag;
            sa[0] <= fpu_add;
            for (int s = 1; s < NSTAGE; s++) begin
                sy[s] <= sy[s-1];
                sf[s] <= sf[s-1];
                sa[s] <= sa[s-1];
            end
        end
    end
    assign fpu_y = sy[NSTAGE-1];
    assign fpu_flagout = sf[NSTAGE-1];
    assign fpu_addout = sa[NSTAGE-1] ^ tag_xor;
    // inputs change only at posedge+1, so negedge sees what the next edge will accept
    always @(negedge clk) begin
        if (rstn) begin
            if (res_valid != '0) begin
                total++;
                pops++;
                if (sb.size() == 0) $display("FAIL result_unexpected res_valid=%b scoreboard empty", res_valid);
                else begin
                    e = sb.pop_front();
                    outst[e.id]--;
                    if (res_valid !== (NREQ'(1) << e.id) || res_y !== e.y || res_rd !== e.rd)
                        $display("FAIL result got valid=%b y=%h rd=%0d want valid=%b y=%h rd=%0d",
                                 res_valid, res_y, res_rd, NREQ'(1) << e.id, e.y, e.rd);
                    else passed++;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    mb = req_x2[32*i +: 32];
                    sb.push_back('{i, req_rd[5*i +: 5] ^ tag_xor, req_x1[32*i +: 32] + {mb[31] ^ req_sub[i], mb[30:0]}});
                    gq.push_back(i);
                    outst[i]++;
                    if (outst[i] > max_out) max_out = outst[i];
                end
            end
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s, input logic [4:0] r);
        req_x1[32*i +: 32] = a;
        req_x2[32*i +: 32] = b;
        req_sub[i] = s;
        req_rd[5*i +: 5] = r;
    endtask
    task automatic drain(output int cyc);
        cyc = 0;
        while ((busy || res_valid != '0) && cyc < 100) begin
            step();
            cyc++;
        end
    endtask
    task automatic test_reset();
        rstn = 1'b0;
        hold = 1'b0;
        tag_xor = '0;
        req_valid = '1;
        req_x1 = '1;
        req_x2 = '1;
        req_sub = '0;
        req_rd = '1;
        #3;
        total++; if (req_ready !== '0) $display("FAIL reset_ready got %b want 0", req_ready); else passed++;
        total++; if ({fpu_flag, fpu_x1, fpu_x2, fpu_add} !== '0) $display("FAIL reset_fpu got %b %h %h %h want 0", fpu_flag, fpu_x1, fpu_x2, fpu_add); else passed++;
        total++; if ({res_valid, res_y, res_rd} !== '0) $display("FAIL reset_res got %b %h %h want 0", res_valid, res_y, res_rd); else passed++;
        total++; if ({busy, err} !== 2'b00) $display("FAIL reset_busy_err got %b%b want 00", busy, err); else passed++;
        step();
        step();
        rstn = 1'b1;
        #1;
        total++; if (req_ready !== 2'b01) $display("FAIL reset_priority got %b want 01", req_ready); else passed++;
        req_valid = '0;
    endtask
    task automatic test_single();
        set_op(0, 32'h3F800000, 32'h40000000, 1'b0, 5'd5);
        req_valid = 2'b01;
        #1;
        total++; if (req_ready !== 2'b01) $display("FAIL single_ready got %b want 01", req_ready); else passed++;
        step();
        req_valid = '0;
        total++; if ({fpu_flag, fpu_x1, fpu_x2, fpu_add} !== {1'b1, 32'h3F800000, 32'h40000000, 5'd5})
            $display("FAIL single_issue got %b %h %h %0d want 1 3f800000 40000000 5", fpu_flag, fpu_x1, fpu_x2, fpu_add); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL single_busy got %b want 1", busy); else passed++;
        repeat (NSTAGE) step();
        total++; if (res_valid !== '0) $display("FAIL single_early got %b want 00", res_valid); else passed++;
        step();
        total++; if ({res_valid, res_y, res_rd} !== {2'b01, 32'h7F800000, 5'd5})
            $display("FAIL single_result got %b %h %0d want 01 7f800000 5", res_valid, res_y, res_rd); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL single_idle got %b want 0", busy); else passed++;
        step();
        total++; if ({res_valid, res_rd} !== {2'b00, 5'd5}) $display("FAIL single_pulse got %b %0d want 00 5", res_valid, res_rd); else passed++;
    endtask
    task automatic test_sub();
        int c;
        set_op(1, 32'h40400000, 32'h3F800000, 1'b1, 5'd7);
        req_valid = 2'b10;
        #1;
        total++; if (req_ready !== 2'b10) $display("FAIL sub_ready got %b want 10", req_ready); else passed++;
        step();
        req_valid = '0;
        total++; if ({fpu_x1, fpu_x2, fpu_add} !== {32'h40400000, 32'hBF800000, 5'd7})
            $display("FAIL sub_issue got %h %h %0d want 40400000 bf800000 7", fpu_x1, fpu_x2, fpu_add); else passed++;
        drain(c);
        total++; if (c >= 100 || sb.size() != 0) $display("FAIL sub_drain got cycles=%0d pending=%0d want <100 0", c, sb.size()); else passed++;
    endtask
    task automatic test_round_robin();
        int c;
        gq.delete();
        set_op(0, $urandom, $urandom, 1'b0, 5'd3);
        set_op(1, $urandom, $urandom, 1'b1, 5'd9);
        req_valid = 2'b11;
        repeat (8) begin
            step();
            set_op(0, $urandom, $urandom, 1'($urandom_range(1)), 5'd3);
            set_op(1, $urandom, $urandom, 1'($urandom_range(1)), 5'd9);
        end
        req_valid = '0;
        total++; if (gq.size() != 8) $display("FAIL rr_count got %0d want 8", gq.size()); else passed++;
        for (int j = 0; j < gq.size(); j++) begin
            total++; if (gq[j] != j % 2) $display("FAIL rr_order[%0d] got %0d want %0d", j, gq[j], j % 2); else passed++;
        end
        drain(c);
        total++; if (c >= 100 || sb.size() != 0) $display("FAIL rr_drain got cycles=%0d pending=%0d want <100 0", c, sb.size()); else passed++;
    endtask
    task automatic test_credit();
        int c;
        max_out = 0;
        set_op(0, 32'h12345678, 32'h01010101, 1'b0, 5'd17);
        req_valid = 2'b01;
        for (int j = 0; j < 15; j++) begin
            #1;
            total++; if (req_ready[0] !== ((j % (NSTAGE + 2)) < MAXOUT))
                $display("FAIL credit_ready[%0d] got %b want %b", j, req_ready[0], (j % (NSTAGE + 2)) < MAXOUT); else passed++;
            step();
        end
        req_valid = '0;
        drain(c);
        total++; if (max_out != MAXOUT) $display("FAIL credit_max got %0d want %0d", max_out, MAXOUT); else passed++;
        total++; if (c >= 100 || sb.size() != 0) $display("FAIL credit_drain got cycles=%0d pending=%0d want <100 0", c, sb.size()); else passed++;
    endtask
    task automatic test_hold();
        int c, p0;
        gq.delete();
        p0 = pops;
        set_op(0, 32'h0000_1000, 32'h0000_0020, 1'b0, 5'd1);
        set_op(1, 32'h0000_2000, 32'h0000_0030, 1'b1, 5'd2);
        req_valid = 2'b11;
        step();
        step();
        hold = 1'b1;
        #1;
        total++; if (req_ready !== '0) $display("FAIL hold_ready_now got %b want 00", req_ready); else passed++;
        repeat (3) begin
            step();
            total++; if ({req_ready, fpu_flag} !== 3'b000) $display("FAIL hold_blocked got %b %b want 00 0", req_ready, fpu_flag); else passed++;
        end
        hold = 1'b0;
        req_valid = '0;
        drain(c);
        total++; if (gq.size() != 2 || pops - p0 != 2) $display("FAIL hold_ops got grants=%0d results=%0d want 2 2", gq.size(), pops - p0); else passed++;
        total++; if (c >= 100 || busy !== 1'b0 || err !== 1'b0) $display("FAIL hold_end got cycles=%0d busy=%b err=%b want <100 0 0", c, busy, err); else passed++;
    endtask
    task automatic test_reset_mid();
        int p0;
        req_valid = 2'b11;
        repeat (3) step();
        req_valid = '0;
        rstn = 1'b0;
        #1;
        total++; if ({fpu_flag, fpu_x1, fpu_x2, fpu_add, res_valid, res_y, res_rd, busy, err} !== '0)
            $display("FAIL midreset_outputs got flag=%b busy=%b res_valid=%b want 0 0 00", fpu_flag, busy, res_valid); else passed++;
        sb.delete();
        for (int i = 0; i < NREQ; i++) outst[i] = 0;
        p0 = pops;
        repeat (3) step();
        rstn = 1'b1;
        repeat (NSTAGE + 4) step();
        total++; if (pops != p0 || busy !== 1'b0) $display("FAIL midreset_quiet got results=%0d busy=%b want 0 0", pops - p0, busy); else passed++;
    endtask
    task automatic test_checker();
        int c;
        total++; if (err !== 1'b0) $display("FAIL chk_clean got %b want 0", err); else passed++;
        tag_xor = 5'd1;
        set_op(0, 32'h00000004, 32'h00000003, 1'b0, 5'd12);
        req_valid = 2'b01;
        step();
        req_valid = '0;
        repeat (NSTAGE) step();
        total++; if (err !== 1'b0) $display("FAIL chk_before got %b want 0", err); else passed++;
        step();
        tag_xor = '0;
        total++; if (err !== 1'b1) $display("FAIL chk_set got %b want 1", err); else passed++;
        set_op(1, 32'h00000010, 32'h00000001, 1'b0, 5'd20);
        req_valid = 2'b10;
        step();
        req_valid = '0;
        drain(c);
        total++; if (err !== 1'b1 || c >= 100) $display("FAIL chk_sticky got err=%b cycles=%0d want 1 <100", err, c); else passed++;
        rstn = 1'b0;
        #1;
        total++; if (err !== 1'b0) $display("FAIL chk_reset got %b want 0", err); else passed++;
        step();
        rstn = 1'b1;
    endtask
    initial begin
        for (int i = 0; i < NREQ; i++) outst[i] = 0;
        test_reset();
        test_single();
        test_sub();
        test_round_robin();
        test_credit();
        test_hold();
        test_reset_mid();
        test_checker();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
